// File: rtl/permute_arbiter.sv
// Registered arbitration stage for a two-input deflection permuter: picks the
// higher-priority flit, derives the permuter swap control and ages both flits.
module permute_arbiter #(
   parameter int WIDTH        = 64,
   parameter int VALID_BIT    = 63,
   parameter int AGE_LSB      = 0,
   parameter int AGE_W        = 8,
   parameter int DIR_BIT      = 62,
   parameter int ID_LSB       = 8,
   parameter int ID_W         = 4,
   parameter int GOLDEN_EPOCH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] inFlit0,
   input  logic [WIDTH-1:0] inFlit1,
   output logic [WIDTH-1:0] outFlit0,
   output logic [WIDTH-1:0] outFlit1,
   output logic             swap,
   output logic [ID_W-1:0]  golden_id
);

   localparam int EP_W = (GOLDEN_EPOCH > 2) ? $clog2(GOLDEN_EPOCH) : 1;
   localparam logic [EP_W-1:0] EP_LAST = EP_W'(GOLDEN_EPOCH - 1);

   logic [WIDTH-1:0] flit0_p1, flit1_p1;
   logic             swap_p1;
   logic [EP_W-1:0]  ep_cnt;
   logic             tie_ptr;

   logic             v0, v1, g0, g1;
   logic [AGE_W-1:0] age0, age1;
   logic             win_any, win1, tie_hit, swap_d;

   function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
      return (&a) ? a : a + AGE_W'(1);
   endfunction

   function automatic logic [WIDTH-1:0] age_flit(input logic [WIDTH-1:0] f);
      logic [WIDTH-1:0] r;
      r = f;
      if (f[VALID_BIT])
         r[AGE_LSB +: AGE_W] = sat_inc(f[AGE_LSB +: AGE_W]);
      return r;
   endfunction

   always_comb begin
      v0      = inFlit0[VALID_BIT];
      v1      = inFlit1[VALID_BIT];
      g0      = v0 && (inFlit0[ID_LSB +: ID_W] == golden_id);
      g1      = v1 && (inFlit1[ID_LSB +: ID_W] == golden_id);
      age0    = inFlit0[AGE_LSB +: AGE_W];
      age1    = inFlit1[AGE_LSB +: AGE_W];
      win_any = v0 | v1;
      win1    = v1;
      tie_hit = 1'b0;
      if (v0 && v1) begin
         if (g0 != g1)
            win1 = g1;
         else if (age0 != age1)
            win1 = (age1 > age0);
         else begin
            win1    = tie_ptr;
            tie_hit = 1'b1;
         end
      end
      // Swap when the winner sits on the opposite side of its desired output.
      swap_d = win_any && (win1 ? !inFlit1[DIR_BIT] : inFlit0[DIR_BIT]);
   end

   // Stage p1: registered flits, swap and arbitration state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flit0_p1  <= '0;
         flit1_p1  <= '0;
         swap_p1   <= 1'b0;
         tie_ptr   <= 1'b0;
         ep_cnt    <= '0;
         golden_id <= '0;
      end else begin
         flit0_p1 <= age_flit(inFlit0);
         flit1_p1 <= age_flit(inFlit1);
         swap_p1  <= swap_d;
         if (tie_hit)
            tie_ptr <= !tie_ptr;
         if (ep_cnt == EP_LAST) begin
            ep_cnt    <= '0;
            golden_id <= golden_id + ID_W'(1);
         end else begin
            ep_cnt <= ep_cnt + EP_W'(1);
         end
      end
   end

   assign outFlit0 = flit0_p1;
   assign outFlit1 = flit1_p1;
   assign swap     = swap_p1;

endmodule

// File: tb/tb_permute_arbiter.sv
// Scoreboard bench for permute_arbiter: a priority/epoch reference model queues
// expected outputs per sampled pair; a monitor compares after each clock edge.
module tb_permute_arbiter;

   localparam int EPOCH = 64;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] in0, in1;
   logic [63:0] out0, out1;
   logic        swap;
   logic [3:0]  gid;

   typedef struct {
      logic [63:0] f0;
      logic [63:0] f1;
      logic        sw;
      logic [3:0]  gid;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   n_edges = 0;
   int   n_ties = 0;
   bit   active = 1'b0;

   always #5 clk = ~clk;

   permute_arbiter dut (
      .clk(clk), .rst_n(rst_n), .inFlit0(in0), .inFlit1(in1),
      .outFlit0(out0), .outFlit1(out1), .swap(swap), .golden_id(gid)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [63:0] mk(input bit v, input bit dir, input int id, input int age);
      logic [63:0] f;
      f = {$urandom, $urandom};
      f[63] = v;
      f[62] = dir;
      f[11:8] = id[3:0];
      f[7:0] = age[7:0];
      return f;
   endfunction

   function automatic logic [63:0] aged(input logic [63:0] f);
      logic [63:0] r;
      int a;
      r = f;
      if (f[63]) begin
         a = int'(f[7:0]) + 1;
         if (a > 255) a = 255;
         r[7:0] = a[7:0];
      end
      return r;
   endfunction

   function automatic logic [63:0] rnd_flit();
      int age;
      age = ($urandom_range(0, 3) == 0) ? 250 + $urandom_range(0, 5) : $urandom_range(0, 12);
      return mk($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 15), age);
   endfunction

   // Drive one pair at a falling edge, queue its expected result, advance a cycle.
   task automatic cycle(input logic [63:0] f0, input logic [63:0] f1);
      exp_t e;
      int gb, a0, a1, p0, p1, w;
      bit g0, g1;
      in0 = f0;
      in1 = f1;
      gb = (n_edges / EPOCH) % 16;
      a0 = int'(f0[7:0]);
      a1 = int'(f1[7:0]);
      g0 = f0[63] && (int'(f0[11:8]) == gb);
      g1 = f1[63] && (int'(f1[11:8]) == gb);
      w = -1;
      if (f0[63] && f1[63]) begin
         p0 = (g0 ? 1000 : 0) + a0;
         p1 = (g1 ? 1000 : 0) + a1;
         if (p0 > p1) w = 0;
         else if (p1 > p0) w = 1;
         else begin
            w = n_ties % 2;
            n_ties++;
         end
      end else if (f0[63]) w = 0;
      else if (f1[63]) w = 1;
      e.f0 = aged(f0);
      e.f1 = aged(f1);
      e.sw = (w == 0 && f0[62]) || (w == 1 && !f1[62]);
      n_edges++;
      e.gid = 4'((n_edges / EPOCH) % 16);
      q.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   always @(posedge clk) begin
      #1;
      if (rst_n && active) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty actual=0 entries required=1 entry");
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("sb_out0", out0, e.f0);
            chk("sb_out1", out1, e.f1);
            chk("sb_swap", 64'(swap), 64'(e.sw));
            chk("sb_gid", 64'(gid), 64'(e.gid));
         end
      end
   end

   // Assert reset off-edge, confirm outputs clear at once, release on a falling edge.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_out0", out0, 64'd0);
      chk("rst_out1", out1, 64'd0);
      chk("rst_swap", 64'(swap), 64'd0);
      chk("rst_gid", 64'(gid), 64'd0);
      active = 1'b0;
      q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n_edges = 0;
      n_ties = 0;
      active = 1'b1;
   endtask

   initial begin
      logic [63:0] a, b, t;
      rst_n = 1'b1;
      in0 = '0;
      in1 = '0;
      @(negedge clk);
      do_reset();

      a = mk(1, 0, 5, 5);
      b = mk(1, 0, 6, 9);
      cycle(a, b);
      chk("age_swap", 64'(swap), 64'd1);
      chk("age_out0", 64'(out0[7:0]), 64'd6);
      chk("age_out1", 64'(out1[7:0]), 64'd10);
      b[62] = 1'b1;
      cycle(a, b);
      chk("age_swap_dir1", 64'(swap), 64'd0);

      cycle(mk(1, 1, 0, 1), mk(1, 0, 3, 200));
      chk("golden_swap", 64'(swap), 64'd1);

      t = mk(1, 1, 7, 7);
      cycle(t, t);
      chk("tie_1", 64'(swap), 64'd1);
      cycle(t, t);
      chk("tie_2", 64'(swap), 64'd0);
      cycle(t, t);
      chk("tie_3", 64'(swap), 64'd1);

      a = mk(0, 0, 1, 3);
      cycle(a, mk(1, 0, 2, 255));
      chk("single_swap", 64'(swap), 64'd1);
      chk("sat_age", 64'(out1[7:0]), 64'd255);
      chk("invalid_pass", out0, a);
      cycle(mk(0, 1, 0, 4), mk(0, 0, 0, 4));
      chk("none_swap", 64'(swap), 64'd0);

      for (int i = 0; i < 200; i++) begin
         a = rnd_flit();
         b = rnd_flit();
         if ($urandom_range(0, 3) == 0) b[11:0] = a[11:0];
         cycle(a, b);
      end

      in0 = mk(1, 1, 2, 40);
      in1 = mk(1, 0, 9, 41);
      do_reset();

      a = rnd_flit();
      b = rnd_flit();
      cycle(a, b);
      chk("post_rst_out0", out0, aged(a));
      chk("post_rst_gid", 64'(gid), 64'd0);
      while (n_edges < EPOCH - 1) cycle(rnd_flit(), rnd_flit());
      chk("gid_before_wrap", 64'(gid), 64'd0);
      a = mk(1, 1, 0, 1);
      b = mk(1, 1, 3, 200);
      cycle(a, b);
      chk("wrap_edge_golden", 64'(swap), 64'd1);
      chk("gid_after_wrap", 64'(gid), 64'd1);
      cycle(a, b);
      chk("old_golden_lost", 64'(swap), 64'd0);
      while (n_edges < 16 * EPOCH - 1) cycle(rnd_flit(), rnd_flit());
      chk("gid_15", 64'(gid), 64'd15);
      cycle(rnd_flit(), rnd_flit());
      chk("gid_wrap0", 64'(gid), 64'd0);

      active = 1'b0;
      chk("sb_drained", 64'(q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/permute_arbiter.md
# permute_arbiter

Registered arbitration stage that computes the `swap` control for a two-input permuter in the bufferless deflection router. Each cycle it compares the priority of two incoming flits (golden packet first, then oldest age, then a rotating tie-break) and decides whether the winner must cross to its desired output. It registers both flits with saturating age increment, so the stage and its `swap` are presented together to the downstream permuter one cycle later. It also owns the golden-packet epoch counter that defines which packet ID is golden.

## Interface
- `WIDTH`, 64: flit width in bits (internal flit format).
- `VALID_BIT`, 63: bit index of the flit valid flag.
- `AGE_LSB`, 0: LSB of the age field.
- `AGE_W`, 8: age field width; age saturates at 2^AGE_W-1.
- `DIR_BIT`, 62: desired-output bit for this permuter stage (0 = out0, 1 = out1).
- `ID_LSB`, 8: LSB of the packet ID field.
- `ID_W`, 4: packet ID width.
- `GOLDEN_EPOCH`, 64: cycles per golden epoch; must be >= 2.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `inFlit0` in WIDTH: flit on input 0.
- `inFlit1` in WIDTH: flit on input 1.
- `outFlit0` out WIDTH: registered input-0 flit, age updated.
- `outFlit1` out WIDTH: registered input-1 flit, age updated.
- `swap` out 1: registered permuter control, aligned with `outFlit0/1`.
- `golden_id` out ID_W: current golden packet ID.

## Operation
- Valid: `v_i = inFlit_i[VALID_BIT]`. Golden: `g_i = v_i && ID field == golden_id`, using the `golden_id` value before this edge.
- Priority order:
  - Golden beats non-golden.
  - Larger age beats smaller age, unsigned.
  - Full tie: the winner is the input named by internal pointer `tie_ptr`.
- Only one valid flit: that flit wins, with no compare. Neither valid: no winner.
- `swap` next = 1 if winner is input 0 and its DIR bit = 1, or winner is input 1 and its DIR bit = 0. Otherwise 0, including the no-winner case.
- The loser is deflected implicitly by the permuter. This block never drops or alters the loser's fields other than age.
- Age update, each valid flit independently: `age + 1`, held at 2^AGE_W-1 when already saturated. Invalid flits pass through unchanged; age is not incremented.
- `tie_ptr`: toggles only on a cycle where both flits are valid and the tie-break decided the winner. Otherwise it holds.
- Epoch counter `ep_cnt`, 0..GOLDEN_EPOCH-1:
  - Increments every cycle.
  - At GOLDEN_EPOCH-1 it wraps to 0, and `golden_id` increments modulo 2^ID_W on the same edge.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on `outFlit0/1`, with `swap`, after edge N.
- Fully pipelined: a new flit pair is accepted every cycle, with no backpressure and no stall.
- Reset (`rst_n` low, asynchronous): `outFlit0/1` = 0, `swap` = 0, `golden_id` = 0, `ep_cnt` = 0, `tie_ptr` = 0. Outputs change immediately, without waiting for `clk`.
- Reset mid-traffic: in-flight flits are discarded. The first edge after `rst_n` rises samples fresh inputs, and the epoch restarts at 0.
- Epoch boundary: a flit sampled on the wrap edge is compared against the old `golden_id`. The new ID applies from the next edge.
- `golden_id` wrap: 2^ID_W-1 goes to 0.
- Both golden: age decides, then `tie_ptr`.

## Test plan
- Reset:
  - Stimulus: assert `rst_n` low mid-stream with valid flits.
  - Required response: outputs go to 0 without a clock edge; after release, `golden_id` = 0 and the first output appears 1 cycle after the first sample.
- Age priority:
  - Stimulus: flit0 age 5, DIR 0; flit1 age 9, DIR 0.
  - Required response, next cycle: `swap` = 1, out ages 6 and 10.
  - Stimulus: same pair with flit1 DIR 1.
  - Required response: `swap` = 0.
- Golden override:
  - Stimulus: `golden_id` = 0; flit0 ID 0, age 1, DIR 1; flit1 ID 3, age 200.
  - Required response: `swap` = 1.
- Tie rotation:
  - Stimulus: identical non-golden flits with age 7, flit0 DIR 1, flit1 DIR 1, on 3 consecutive cycles.
  - Required response: `swap` = 1, 0, 1.
- Single valid and saturation:
  - Stimulus: only flit1 valid, age 255, DIR 0.
  - Required response: `swap` = 1, age stays 255; the invalid flit0 passes unchanged.
  - Stimulus: both flits invalid.
  - Required response: `swap` = 0.
- Epoch:
  - Stimulus: run GOLDEN_EPOCH cycles.
  - Required response: `golden_id` 0→1 exactly after cycle 64; after 16×64 cycles it wraps to 0.
  - Stimulus: a flit with ID 0 sampled on the wrap edge.
  - Required response: it is still treated as golden.
